// File: rtl/spi_pkg.sv
// Shared SPI master types: FSM state encoding, latched bus mode, and the
// slave-select index width rule.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD
    } spi_state_e;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    function automatic int ss_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period timer for the SPI master: counts H = div_i+1 cycles per half
// period and flags leading/trailing sck edges and the final edge of a word.
module spi_clk_gen #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             run_i,
    input  logic             shift_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o,
    output logic             lead_o,
    output logic             trail_o,
    output logic             last_o
);
    localparam int HP_W = $clog2(2 * DATA_W);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [HP_W-1:0]  hp_q, hp_d;

    // Counter runs 0..div_i, so all-ones div_i gives 2^DIV_W cycles without overflow.
    assign tick_o  = run_i && (cnt_q == div_i);
    assign lead_o  = tick_o && shift_i && !hp_q[0];
    assign trail_o = tick_o && shift_i && hp_q[0];
    assign last_o  = trail_o && (hp_q == HP_W'(2 * DATA_W - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!run_i || tick_o) begin
            cnt_d = '0;
        end
        hp_d = hp_q;
        if (!shift_i) begin
            hp_d = '0;
        end else if (tick_o) begin
            hp_d = hp_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            hp_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            hp_q  <= hp_d;
        end
    end

endmodule

// File: rtl/spi_master_gen.sv
// Generic SPI master: one DATA_W-bit full-duplex transfer per request, all
// four SPI modes, programmable sck half-period, NUM_SS one-hot-low selects.
module spi_master_gen
    import spi_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int NUM_SS = 1,
    parameter  int DIV_W  = 8,
    localparam int SS_W   = ss_width(NUM_SS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [SS_W-1:0]   ss_sel,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [DIV_W-1:0]  clk_div,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              sck,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_SS-1:0] ss_n
);
    spi_state_e        state_q, state_d;
    spi_mode_t         mode_q, mode_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [SS_W-1:0]   ss_q, ss_d;
    logic [DATA_W-1:0] txsh_q, txsh_d;
    logic [DATA_W-1:0] rxsh_q, rxsh_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic [NUM_SS-1:0] ss_n_q, ss_n_d;
    logic              sck_q, sck_d;
    logic              mosi_q, mosi_d;
    logic              rx_valid_q, rx_valid_d;
    logic              busy_q, busy_d;
    logic              tx_ready_q, tx_ready_d;
    logic              accept, tick, lead, trail, last;

    spi_clk_gen #(
        .DATA_W (DATA_W),
        .DIV_W  (DIV_W)
    ) u_clk_gen (
        .clk_i   (clk),
        .rst_i   (rst),
        .run_i   (state_q != ST_IDLE),
        .shift_i (state_q == ST_SHIFT),
        .div_i   (div_q),
        .tick_o  (tick),
        .lead_o  (lead),
        .trail_o (trail),
        .last_o  (last)
    );

    assign accept = (state_q == ST_IDLE) && tx_valid && tx_ready_q;

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        div_d      = div_q;
        ss_d       = ss_q;
        txsh_d     = txsh_q;
        rxsh_d     = rxsh_q;
        sck_d      = sck_q;
        mosi_d     = mosi_q;
        rx_valid_d = 1'b0;
        rx_data_d  = rx_data_q;
        case (state_q)
            ST_IDLE: begin
                sck_d  = cpol;
                mosi_d = 1'b0;
                if (accept) begin
                    state_d = ST_SETUP;
                    mode_d  = '{cpol: cpol, cpha: cpha};
                    div_d   = clk_div;
                    ss_d    = ss_sel;
                    txsh_d  = tx_data;
                    // cpha=0 slaves sample on the first edge, so MSB must already be out.
                    mosi_d  = cpha ? 1'b0 : tx_data[DATA_W-1];
                end
            end
            ST_SETUP: begin
                if (tick) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (tick) sck_d = ~sck_q;
                if (lead) begin
                    if (mode_q.cpha) begin
                        mosi_d = txsh_q[DATA_W-1];
                        txsh_d = txsh_q << 1;
                    end else begin
                        rxsh_d = {rxsh_q[DATA_W-2:0], miso};
                    end
                end
                if (trail) begin
                    if (mode_q.cpha) begin
                        rxsh_d = {rxsh_q[DATA_W-2:0], miso};
                    end else if (!last) begin
                        mosi_d = txsh_q[DATA_W-2];
                        txsh_d = txsh_q << 1;
                    end
                end
                if (last) begin
                    state_d = ST_HOLD;
                    sck_d   = mode_q.cpol;
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    state_d    = ST_IDLE;
                    mosi_d     = 1'b0;
                    rx_valid_d = 1'b1;
                    rx_data_d  = rxsh_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Out-of-range selects match no line, leaving every ss_n high.
        ss_n_d = '1;
        for (int i = 0; i < NUM_SS; i++) begin
            ss_n_d[i] = !((state_d != ST_IDLE) && (ss_d == SS_W'(i)));
        end
        busy_d     = (state_d != ST_IDLE);
        tx_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mode_q     <= '0;
            div_q      <= '0;
            ss_q       <= '0;
            txsh_q     <= '0;
            rxsh_q     <= '0;
            rx_data_q  <= '0;
            ss_n_q     <= '1;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            tx_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            div_q      <= div_d;
            ss_q       <= ss_d;
            txsh_q     <= txsh_d;
            rxsh_q     <= rxsh_d;
            rx_data_q  <= rx_data_d;
            ss_n_q     <= ss_n_d;
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
            rx_valid_q <= rx_valid_d;
            busy_q     <= busy_d;
            tx_ready_q <= tx_ready_d;
        end
    end

    assign tx_ready = tx_ready_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign busy     = busy_q;
    assign sck      = sck_q;
    assign mosi     = mosi_q;
    assign ss_n     = ss_n_q;

endmodule

// File: tb/tb_spi_master_gen.sv
// Bench for spi_master_gen: an 8-bit/3-select instance with an edge-counting
// slave model and a 16-bit/1-select loopback instance.
module tb_spi_master_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic       a_tx_valid = 1'b0, a_cpol = 1'b0, a_cpha = 1'b0;
    logic       a_tx_ready, a_rx_valid, a_busy, a_sck, a_mosi, a_miso;
    logic [7:0] a_tx_data = 8'h00, a_div = 8'h00;
    logic [7:0] a_rx_data;
    logic [1:0] a_sel = 2'd0;
    logic [2:0] a_ss_n;

    logic        b_tx_valid = 1'b0, b_cpol = 1'b0, b_cpha = 1'b0;
    logic        b_tx_ready, b_rx_valid, b_busy, b_sck, b_mosi;
    logic [15:0] b_tx_data = 16'h0000;
    logic [15:0] b_rx_data;
    logic [7:0]  b_div = 8'h00;
    logic [0:0]  b_sel = 1'b0;
    logic [0:0]  b_ss_n;

    // Slave model: the bit on miso is picked purely from how many sck edges
    // have occurred since the transfer began and from the clock phase.
    bit         sl_en    = 1'b0;
    bit         sl_cpha  = 1'b0;
    logic [7:0] sl_word  = 8'h00;
    int         sl_edges = 0;
    int         sl_base  = 0;

    always @(a_sck) sl_edges++;

    function automatic logic slave_bit(input int e, input bit cph, input logic [7:0] w);
        int idx;
        idx = cph ? ((e + 1) / 2 - 1) : (e / 2);
        return (idx >= 0 && idx < 8) ? w[7-idx] : 1'b0;
    endfunction

    assign a_miso = sl_en ? slave_bit(sl_edges - sl_base, sl_cpha, sl_word) : a_mosi;

    spi_master_gen #(.DATA_W(8), .NUM_SS(3), .DIV_W(8)) u_a (
        .clk(clk), .rst(rst), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
        .tx_data(a_tx_data), .ss_sel(a_sel), .cpol(a_cpol), .cpha(a_cpha),
        .clk_div(a_div), .rx_valid(a_rx_valid), .rx_data(a_rx_data), .busy(a_busy),
        .sck(a_sck), .mosi(a_mosi), .miso(a_miso), .ss_n(a_ss_n)
    );

    spi_master_gen #(.DATA_W(16), .NUM_SS(1), .DIV_W(8)) u_b (
        .clk(clk), .rst(rst), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
        .tx_data(b_tx_data), .ss_sel(b_sel), .cpol(b_cpol), .cpha(b_cpha),
        .clk_div(b_div), .rx_valid(b_rx_valid), .rx_data(b_rx_data), .busy(b_busy),
        .sck(b_sck), .mosi(b_mosi), .miso(b_mosi), .ss_n(b_ss_n)
    );

    // Runs one transfer on instance A and reports what was observed.
    task automatic xfer8(input logic [7:0] d, input logic cp, input logic ch,
                         input logic [7:0] div, input logic [1:0] sel,
                         input bit slave, input logic [7:0] sw,
                         output logic [7:0] rx, output int busy_n, output int rises,
                         output int ss_bad, output int pulses, output logic sck0,
                         output logic rdy, output bit tmo);
        int cyc;
        logic prev;
        logic [2:0] exp_ss;
        busy_n = 0; rises = 0; ss_bad = 0; pulses = 0; tmo = 1'b0;
        rx = 8'h00; sck0 = 1'bx; rdy = 1'b0;
        exp_ss = (sel < 2'd3) ? ~(3'b001 << sel) : 3'b111;
        cyc = 0;
        while (!a_tx_ready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        if (!a_tx_ready) begin
            tmo = 1'b1;
            return;
        end
        a_tx_data = d; a_cpol = cp; a_cpha = ch; a_div = div; a_sel = sel;
        sl_en = slave; sl_word = sw; sl_cpha = ch;
        a_tx_valid = 1'b1;
        @(posedge clk);
        #1;
        a_tx_valid = 1'b0;
        a_tx_data  = 8'($urandom);
        a_cpha     = 1'($urandom);
        a_div      = 8'($urandom);
        a_sel      = 2'($urandom);
        sl_base    = sl_edges;
        prev       = a_sck;
        cyc = 0;
        while (cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) sck0 = a_sck;
            if (a_rx_valid) begin
                pulses++;
                rx  = a_rx_data;
                rdy = a_tx_ready;
                if (a_ss_n !== 3'b111) ss_bad++;
                break;
            end
            if (a_busy) busy_n++;
            if (a_sck === 1'b1 && prev === 1'b0) rises++;
            prev = a_sck;
            if (a_ss_n !== exp_ss) ss_bad++;
        end
        if (pulses == 0) tmo = 1'b1;
        @(negedge clk);
        if (a_rx_valid) pulses++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++; if (a_sck !== 1'b0) begin n_fail++; $display("FAIL reset_sck: got %b want 0", a_sck); end
        n_chk++; if (a_mosi !== 1'b0) begin n_fail++; $display("FAIL reset_mosi: got %b want 0", a_mosi); end
        n_chk++; if (a_ss_n !== 3'b111) begin n_fail++; $display("FAIL reset_ss_n: got %b want 111", a_ss_n); end
        n_chk++; if (a_rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b want 0", a_rx_valid); end
        n_chk++; if (a_rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h want 00", a_rx_data); end
        n_chk++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", a_busy); end
        n_chk++; if (a_tx_ready !== 1'b0) begin n_fail++; $display("FAIL reset_tx_ready: got %b want 0", a_tx_ready); end
        n_chk++; if (b_ss_n !== 1'b1) begin n_fail++; $display("FAIL reset_b_ss_n: got %b want 1", b_ss_n); end
        rst = 1'b0;
        @(negedge clk);
        n_chk++; if (a_tx_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset: got %b want 1", a_tx_ready); end
        n_chk++; if (b_tx_ready !== 1'b1) begin n_fail++; $display("FAIL b_ready_after_reset: got %b want 1", b_tx_ready); end
    endtask

    task automatic test_idle_sck();
        a_cpol = 1'b1;
        @(negedge clk);
        n_chk++; if (a_sck !== 1'b1) begin n_fail++; $display("FAIL idle_sck_cpol1: got %b want 1", a_sck); end
        a_cpol = 1'b0;
        @(negedge clk);
        n_chk++; if (a_sck !== 1'b0) begin n_fail++; $display("FAIL idle_sck_cpol0: got %b want 0", a_sck); end
    endtask

    task automatic test_mode0();
        logic [7:0] rx; int bn, rs, sb, pl; logic s0, rdy; bit tmo;
        xfer8(8'hA5, 1'b0, 1'b0, 8'd0, 2'd0, 1'b0, 8'h00, rx, bn, rs, sb, pl, s0, rdy, tmo);
        n_chk++; if (tmo) begin n_fail++; $display("FAIL mode0_timeout: got timeout want completion"); end
        n_chk++; if (rx !== 8'hA5) begin n_fail++; $display("FAIL mode0_rx: got %h want a5", rx); end
        n_chk++; if (bn != 18) begin n_fail++; $display("FAIL mode0_busy: got %0d want 18", bn); end
        n_chk++; if (rs != 8) begin n_fail++; $display("FAIL mode0_rises: got %0d want 8", rs); end
        n_chk++; if (sb != 0) begin n_fail++; $display("FAIL mode0_ss_n: got %0d bad cycles want 0", sb); end
        n_chk++; if (pl != 1) begin n_fail++; $display("FAIL mode0_pulses: got %0d want 1", pl); end
        n_chk++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL mode0_ready_at_rx: got %b want 1", rdy); end
    endtask

    task automatic test_mode3();
        logic [7:0] rx; int bn, rs, sb, pl; logic s0, rdy; bit tmo;
        xfer8(8'h3C, 1'b1, 1'b1, 8'd2, 2'd0, 1'b1, 8'hC3, rx, bn, rs, sb, pl, s0, rdy, tmo);
        n_chk++; if (rx !== 8'hC3) begin n_fail++; $display("FAIL mode3_rx: got %h want c3", rx); end
        n_chk++; if (bn != 54) begin n_fail++; $display("FAIL mode3_busy: got %0d want 54", bn); end
        n_chk++; if (rs != 8) begin n_fail++; $display("FAIL mode3_rises: got %0d want 8", rs); end
        n_chk++; if (s0 !== 1'b1) begin n_fail++; $display("FAIL mode3_setup_sck: got %b want 1", s0); end
        a_cpol = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++; if (a_sck !== 1'b1) begin n_fail++; $display("FAIL mode3_idle_sck: got %b want 1", a_sck); end
        a_cpol = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [7:0] rx0, rx1; int pulses, cyc, run, gap, ngaps; bit seen_low; logic rdy0;
        rx0 = 8'h00; rx1 = 8'h00; pulses = 0; cyc = 0; run = 0; gap = -1; ngaps = 0;
        seen_low = 1'b0; rdy0 = 1'b0; sl_en = 1'b0;
        a_cpol = 1'b0; a_cpha = 1'b0; a_div = 8'd0; a_sel = 2'd0;
        a_tx_data = 8'h01; a_tx_valid = 1'b1;
        @(posedge clk);
        #1 a_tx_data = 8'h80;
        while (pulses < 2 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (a_ss_n[0] === 1'b0) begin
                if (seen_low && run > 0) begin gap = run; ngaps++; end
                seen_low = 1'b1;
                run = 0;
            end else if (seen_low) begin
                run++;
            end
            if (a_rx_valid) begin
                if (pulses == 0) begin rx0 = a_rx_data; rdy0 = a_tx_ready; end
                else rx1 = a_rx_data;
                pulses++;
                if (pulses == 1) begin
                    @(posedge clk);
                    #1 a_tx_valid = 1'b0;
                end
            end
        end
        a_tx_valid = 1'b0;
        n_chk++; if (pulses != 2) begin n_fail++; $display("FAIL b2b_pulses: got %0d want 2", pulses); end
        n_chk++; if (rx0 !== 8'h01) begin n_fail++; $display("FAIL b2b_rx0: got %h want 01", rx0); end
        n_chk++; if (rx1 !== 8'h80) begin n_fail++; $display("FAIL b2b_rx1: got %h want 80", rx1); end
        n_chk++; if (gap != 1 || ngaps != 1) begin n_fail++; $display("FAIL b2b_ss_gap: got gap %0d count %0d want 1 1", gap, ngaps); end
        n_chk++; if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_at_rx: got %b want 1", rdy0); end
        @(negedge clk);
        n_chk++; if (a_rx_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_strobe_width: got %b want 0", a_rx_valid); end
    endtask

    task automatic test_bad_sel();
        logic [7:0] d, rx; int bn, rs, sb, pl; logic s0, rdy; bit tmo;
        d = 8'($urandom);
        xfer8(d, 1'b0, 1'b0, 8'd1, 2'd3, 1'b0, 8'h00, rx, bn, rs, sb, pl, s0, rdy, tmo);
        n_chk++; if (sb != 0) begin n_fail++; $display("FAIL badsel_ss_n: got %0d bad cycles want 0", sb); end
        n_chk++; if (pl != 1) begin n_fail++; $display("FAIL badsel_pulses: got %0d want 1", pl); end
        n_chk++; if (rx !== d) begin n_fail++; $display("FAIL badsel_rx: got %h want %h", rx, d); end
    endtask

    task automatic test_rst_mid();
        logic [7:0] rx; int bn, rs, sb, pl, rises, cyc; logic s0, rdy, prev; bit tmo;
        sl_en = 1'b0;
        a_cpol = 1'b0; a_cpha = 1'b0; a_div = 8'd1; a_sel = 2'd1;
        a_tx_data = 8'h96; a_tx_valid = 1'b1;
        @(posedge clk);
        #1 a_tx_valid = 1'b0;
        rises = 0; cyc = 0; prev = a_sck;
        while (rises < 4 && cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (a_sck === 1'b1 && prev === 1'b0) rises++;
            prev = a_sck;
        end
        n_chk++; if (rises != 4) begin n_fail++; $display("FAIL rstmid_reach_bit4: got %0d want 4", rises); end
        rst = 1'b1;
        @(negedge clk);
        n_chk++; if (a_ss_n !== 3'b111) begin n_fail++; $display("FAIL rstmid_ss_n: got %b want 111", a_ss_n); end
        n_chk++; if (a_sck !== 1'b0) begin n_fail++; $display("FAIL rstmid_sck: got %b want 0", a_sck); end
        n_chk++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", a_busy); end
        rst = 1'b0;
        pl = 0;
        repeat (40) begin
            @(negedge clk);
            if (a_rx_valid) pl++;
        end
        n_chk++; if (pl != 0) begin n_fail++; $display("FAIL rstmid_no_rx_valid: got %0d pulses want 0", pl); end
        xfer8(8'h5A, 1'b0, 1'b0, 8'd0, 2'd0, 1'b0, 8'h00, rx, bn, rs, sb, pl, s0, rdy, tmo);
        n_chk++; if (rx !== 8'h5A) begin n_fail++; $display("FAIL rstmid_next_rx: got %h want 5a", rx); end
        n_chk++; if (bn != 18) begin n_fail++; $display("FAIL rstmid_next_busy: got %0d want 18", bn); end
    endtask

    task automatic test_w16();
        int div, busy_n, rises, cyc, pulses; logic prev; logic [15:0] rx;
        div = $urandom_range(0, 2);
        busy_n = 0; rises = 0; cyc = 0; pulses = 0; rx = 16'h0000;
        b_div = 8'(div); b_cpol = 1'b0; b_cpha = 1'b1; b_sel = 1'b0;
        b_tx_data = 16'hBEEF; b_tx_valid = 1'b1;
        @(posedge clk);
        #1;
        b_tx_valid = 1'b0;
        b_tx_data  = 16'($urandom);
        b_cpha     = 1'b0;
        prev = b_sck;
        while (cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (b_rx_valid) begin pulses++; rx = b_rx_data; break; end
            if (b_busy) busy_n++;
            if (b_sck === 1'b1 && prev === 1'b0) rises++;
            prev = b_sck;
        end
        n_chk++; if (pulses != 1) begin n_fail++; $display("FAIL w16_done: got %0d pulses want 1", pulses); end
        n_chk++; if (rx !== 16'hBEEF) begin n_fail++; $display("FAIL w16_rx: got %h want beef", rx); end
        n_chk++; if (busy_n != (2 * 16 + 2) * (div + 1)) begin n_fail++; $display("FAIL w16_busy: got %0d want %0d", busy_n, (2 * 16 + 2) * (div + 1)); end
        n_chk++; if (rises != 16) begin n_fail++; $display("FAIL w16_rises: got %0d want 16", rises); end
    endtask

    task automatic test_div_max();
        logic [7:0] d, rx; int bn, rs, sb, pl; logic s0, rdy; bit tmo;
        d = 8'($urandom);
        xfer8(d, 1'($urandom), 1'($urandom), 8'hFF, 2'd2, 1'b0, 8'h00, rx, bn, rs, sb, pl, s0, rdy, tmo);
        n_chk++; if (bn != 18 * 256) begin n_fail++; $display("FAIL divmax_busy: got %0d want %0d", bn, 18 * 256); end
        n_chk++; if (rx !== d) begin n_fail++; $display("FAIL divmax_rx: got %h want %h", rx, d); end
        n_chk++; if (rs != 8) begin n_fail++; $display("FAIL divmax_rises: got %0d want 8", rs); end
    endtask

    task automatic test_random();
        logic [7:0] d, sw, rx, exp_rx; logic cp, ch; logic [7:0] div; logic [1:0] sel; bit slave;
        int bn, rs, sb, pl; logic s0, rdy; bit tmo;
        for (int k = 0; k < 8; k++) begin
            d = 8'($urandom); sw = 8'($urandom);
            cp = 1'($urandom); ch = 1'($urandom);
            div = 8'($urandom_range(0, 3)); sel = 2'($urandom_range(0, 3));
            slave = 1'($urandom);
            exp_rx = slave ? sw : d;
            xfer8(d, cp, ch, div, sel, slave, sw, rx, bn, rs, sb, pl, s0, rdy, tmo);
            n_chk++; if (rx !== exp_rx) begin n_fail++; $display("FAIL rand%0d_rx: got %h want %h", k, rx, exp_rx); end
            n_chk++; if (bn != (2 * 8 + 2) * (int'(div) + 1)) begin n_fail++; $display("FAIL rand%0d_busy: got %0d want %0d", k, bn, (2 * 8 + 2) * (int'(div) + 1)); end
            n_chk++; if (rs != 8) begin n_fail++; $display("FAIL rand%0d_rises: got %0d want 8", k, rs); end
            n_chk++; if (sb != 0) begin n_fail++; $display("FAIL rand%0d_ss_n: got %0d bad cycles want 0", k, sb); end
            n_chk++; if (pl != 1) begin n_fail++; $display("FAIL rand%0d_pulses: got %0d want 1", k, pl); end
            n_chk++; if (s0 !== cp) begin n_fail++; $display("FAIL rand%0d_setup_sck: got %b want %b", k, s0, cp); end
        end
    endtask

    initial begin
        test_reset();
        test_idle_sck();
        test_mode0();
        test_mode3();
        test_back_to_back();
        test_bad_sel();
        test_rst_mid();
        test_w16();
        test_div_max();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
